// File: rtl/manchester_preamble_strip_if.sv
// Byte-wide AXI-Stream bundle used on both sides of the preamble stripper.
// master drives tdata/tvalid/tlast, slave drives tready.
`timescale 1ns/1ps
interface manchester_preamble_strip_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/manchester_preamble_strip.sv
// Hunts preamble+SFD on a decoded byte stream, strips the LEN byte and
// forwards payload with TLAST. Ports: aclk, aresetn, s_axis, m_axis, sync, frame_ok, frame_err.
`timescale 1ns/1ps
module manchester_preamble_strip #(
    parameter int         DATA_WIDTH    = 8,
    parameter int         MIN_PREAMBLE  = 4,
    parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
    parameter logic [7:0] SFD_BYTE      = 8'hD5
) (
    input  logic aclk,
    input  logic aresetn,
    manchester_preamble_strip_if.slave  s_axis,
    manchester_preamble_strip_if.master m_axis,
    output logic sync,
    output logic frame_ok,
    output logic frame_err
);

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD
    } state_t;

    localparam logic [3:0] PRE_MAX = 4'(MIN_PREAMBLE);

    state_t                state;
    logic [3:0]            pre_cnt;
    logic [7:0]            rem;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic                  s_ready;
    logic                  beat;

    // Only payload bytes need room in the single output register.
    assign s_ready = (state != PAYLOAD) | !m_valid_q | m_axis.tready;
    assign beat    = s_axis.tvalid & s_ready;

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= HUNT;
            pre_cnt   <= '0;
            rem       <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            sync      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            // Drain first; a payload load below overrides it in the same cycle.
            if (m_valid_q && m_axis.tready) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                m_data_q  <= '0;
            end

            if (beat) begin
                unique case (state)
                    HUNT: begin
                        if (s_axis.tlast) begin
                            pre_cnt <= '0;
                        end else if (s_axis.tdata == PREAMBLE_BYTE) begin
                            if (pre_cnt != PRE_MAX)
                                pre_cnt <= pre_cnt + 4'd1;
                        end else if (s_axis.tdata == SFD_BYTE &&
                                     pre_cnt == PRE_MAX) begin
                            state   <= LEN;
                            sync    <= 1'b1;
                            pre_cnt <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    LEN: begin
                        if (s_axis.tlast) begin
                            state     <= HUNT;
                            sync      <= 1'b0;
                            frame_err <= 1'b1;
                        end else if (s_axis.tdata == '0) begin
                            state <= HUNT;
                            sync  <= 1'b0;
                        end else begin
                            rem   <= s_axis.tdata;
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        m_data_q  <= s_axis.tdata;
                        m_valid_q <= 1'b1;
                        rem       <= rem - 8'd1;
                        if (rem == 8'd1) begin
                            m_last_q <= 1'b1;
                            frame_ok <= 1'b1;
                            state    <= HUNT;
                            sync     <= 1'b0;
                        end else if (s_axis.tlast) begin
                            // Decoder lost the link mid-payload.
                            m_last_q  <= 1'b1;
                            frame_err <= 1'b1;
                            state     <= HUNT;
                            sync      <= 1'b0;
                        end else begin
                            m_last_q <= 1'b0;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        sync  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_manchester_preamble_strip.sv
// Scoreboard bench for manchester_preamble_strip: directed frames,
// expected payload queued at issue, popped by an output monitor.
`timescale 1ns/1ps
module tb_manchester_preamble_strip;

    logic aclk = 1'b0;
    logic aresetn;
    logic sync;
    logic frame_ok;
    logic frame_err;

    always #5 aclk = ~aclk;

    manchester_preamble_strip_if #(.DATA_WIDTH(8)) s_if ();
    manchester_preamble_strip_if #(.DATA_WIDTH(8)) m_if ();

    manchester_preamble_strip dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .sync      (sync),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    logic [8:0] exp_q[$];
    int n_vec    = 0;
    int n_bad    = 0;
    int ok_cnt   = 0;
    int err_cnt  = 0;
    int sync_cyc = 0;
    bit toggle   = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor and pulse counters.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (frame_ok)  ok_cnt++;
            if (frame_err) err_cnt++;
            if (sync)      sync_cyc++;
            if (!s_if.tready)
                check("s_tready_low_only_when_holding", 32'(1'b1),
                      32'(m_if.tvalid && !m_if.tready));
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL out_unexpected: got %0h expected none",
                             {m_if.tlast, m_if.tdata});
                end else begin
                    check("out_beat", 32'({m_if.tlast, m_if.tdata}),
                          32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Sink backpressure pattern.
    always @(posedge aclk) begin
        #1;
        m_if.tready = toggle ? ~m_if.tready : 1'b1;
    end

    task automatic send(input logic [7:0] d, input logic l);
        int  t;
        bit  acc;
        t = 0;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        do begin
            @(negedge aclk);
            acc = s_if.tready;
            @(posedge aclk);
            #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", d);
        end
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = 8'h00;
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) send(8'h55, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle();
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge aclk);
            t++;
        end
        repeat (3) @(posedge aclk);
        #1;
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic push(input logic l, input logic [7:0] d);
        exp_q.push_back({l, d});
    endtask

    int ok0;
    int err0;

    initial begin
        aresetn     = 1'b0;
        m_if.tready = 1'b1;
        idle();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_m_tlast",  32'(m_if.tlast),  32'd0);
        check("rst_m_tdata",  32'(m_if.tdata),  32'd0);
        check("rst_sync",     32'(sync),        32'd0);
        check("rst_frame_ok", 32'(frame_ok),    32'd0);
        check("rst_frame_err",32'(frame_err),   32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // 1: basic frame
        ok0 = ok_cnt; err0 = err_cnt;
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        push(0, 8'h44); push(1, 8'h55);
        send_pre(4); send(8'hD5, 0); send(8'h05, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        send(8'h44, 0); send(8'h55, 0);
        drain();
        check("t1_frame_ok",  32'(ok_cnt - ok0),   32'd1);
        check("t1_frame_err", 32'(err_cnt - err0), 32'd0);

        // 2: same frame under sink backpressure
        toggle = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt;
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
        push(0, 8'h44); push(1, 8'h55);
        send_pre(4); send(8'hD5, 0); send(8'h05, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        send(8'h44, 0); send(8'h55, 0);
        drain();
        toggle = 1'b0;
        m_if.tready = 1'b1;
        check("t2_frame_ok", 32'(ok_cnt - ok0), 32'd1);

        // 3: short preamble ignored, then long preamble
        ok0 = ok_cnt; err0 = err_cnt;
        send_pre(3); send(8'hD5, 0); send(8'h02, 0);
        send(8'hAA, 0); send(8'hBB, 0);
        push(1, 8'h7E);
        send_pre(6); send(8'hD5, 0); send(8'h01, 0); send(8'h7E, 0);
        drain();
        check("t3_frame_ok",  32'(ok_cnt - ok0),   32'd1);
        check("t3_frame_err", 32'(err_cnt - err0), 32'd0);

        // 4: truncated frame
        ok0 = ok_cnt; err0 = err_cnt;
        push(0, 8'h00); push(1, 8'h01);
        send_pre(4); send(8'hD5, 0); send(8'h04, 0);
        send(8'h00, 0); send(8'h01, 1);
        drain();
        check("t4_frame_ok",  32'(ok_cnt - ok0),   32'd0);
        check("t4_frame_err", 32'(err_cnt - err0), 32'd1);

        // 5: noise, sync symbols inside payload
        ok0 = ok_cnt;
        send(8'h00, 0); send(8'h55, 0); send(8'h13, 0); send(8'h55, 0);
        sync_cyc = 0;
        push(0, 8'h55); push(0, 8'hD5); push(1, 8'h55);
        send_pre(4); send(8'hD5, 0); send(8'h03, 0);
        send(8'h55, 0); send(8'hD5, 0); send(8'h55, 0);
        drain();
        check("t5_sync_cycles", 32'(sync_cyc), 32'd4);
        check("t5_frame_ok",    32'(ok_cnt - ok0), 32'd1);

        // 6: reset mid-frame
        push(0, 8'hA1);
        send_pre(4); send(8'hD5, 0); send(8'h08, 0);
        send(8'hA1, 0); send(8'hA2, 0);
        aresetn = 1'b0;
        idle();
        @(negedge aclk);
        check("t6_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
        check("t6_rst_m_tlast",  32'(m_if.tlast),  32'd0);
        check("t6_rst_m_tdata",  32'(m_if.tdata),  32'd0);
        check("t6_rst_sync",     32'(sync),        32'd0);
        check("t6_queue_empty",  32'(exp_q.size()), 32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        ok0 = ok_cnt;
        push(1, 8'h42);
        send_pre(4); send(8'hD5, 0); send(8'h01, 0); send(8'h42, 0);
        drain();
        check("t6_frame_ok", 32'(ok_cnt - ok0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
